// File: rtl/alarm_pkg.sv
// Shared types and time arithmetic for the alarm bank.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
    } hm_t;

    // n is at most 59, so at most one hour carry can occur
    function automatic hm_t add_min(input logic [4:0] hr, input logic [5:0] min, input logic [5:0] n);
        hm_t        res;
        logic [6:0] m_sum;
        logic [5:0] h_sum;
        m_sum = {1'b0, min} + {1'b0, n};
        if (m_sum > {1'b0, MIN_MAX}) begin
            res.min = 6'(m_sum - 7'd60);
            h_sum   = {1'b0, hr} + 6'd1;
        end else begin
            res.min = m_sum[5:0];
            h_sum   = {1'b0, hr};
        end
        if (h_sum > {1'b0, HR_MAX}) begin
            res.hr = 5'(h_sum - 6'd24);
        end else begin
            res.hr = h_sum[4:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/alarm_time_reg.sv
// One alarm channel: stored hour/minute with edit carry, plus armed bit.
module alarm_time_reg
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       hr_up,
    input  logic       min_up,
    input  logic       arm_tog,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic       armed
);

    logic [4:0] hr_r;
    logic [5:0] min_r;
    logic       armed_r;
    logic       carry_s;
    logic [5:0] min_next_s;
    logic [5:0] hr_sum_s;
    logic [4:0] hr_next_s;

    // Next edited time; hr_up and a minute carry may both add to the hour
    always_comb begin
        carry_s = min_up && (min_r == MIN_MAX);
        if (!min_up) begin
            min_next_s = min_r;
        end else if (carry_s) begin
            min_next_s = 6'd0;
        end else begin
            min_next_s = min_r + 6'd1;
        end
        hr_sum_s = {1'b0, hr_r} + {5'd0, hr_up} + {5'd0, carry_s};
        if (hr_sum_s > {1'b0, HR_MAX}) begin
            hr_next_s = 5'(hr_sum_s - 6'd24);
        end else begin
            hr_next_s = hr_sum_s[4:0];
        end
    end

    // Channel registers; arming is accepted even outside set mode
    always_ff @(posedge clk) begin
        if (rst) begin
            hr_r    <= 5'd0;
            min_r   <= 6'd0;
            armed_r <= 1'b0;
        end else begin
            if (set_mode) begin
                hr_r  <= hr_next_s;
                min_r <= min_next_s;
            end
            if (arm_tog) begin
                armed_r <= ~armed_r;
            end
        end
    end

    assign hr    = hr_r;
    assign min   = min_r;
    assign armed = armed_r;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm: per-second match against the timekeeper, ring/snooze/dismiss event FSM.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int  N_ALM      = 4,
    parameter int  SNOOZE_MIN = 5,
    parameter int  RING_SEC   = 60,
    parameter int  MAX_SNOOZE = 3,
    localparam int SW         = (N_ALM > 1) ? $clog2(N_ALM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic [4:0]       cur_hr,
    input  logic [5:0]       cur_min,
    input  logic [5:0]       cur_sec,
    input  logic             set_mode,
    input  logic [SW-1:0]    sel,
    input  logic             hr_up,
    input  logic             min_up,
    input  logic             arm_tog,
    input  logic             snooze,
    input  logic             dismiss,
    output logic [4:0]       sel_hr,
    output logic [5:0]       sel_min,
    output logic             sel_armed,
    output logic [N_ALM-1:0] armed_mask,
    output logic             ring,
    output logic [SW-1:0]    ring_ch
);

    localparam int         RCW   = $clog2(RING_SEC + 1);
    localparam int         SCW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [5:0] SNZ_N = 6'(SNOOZE_MIN);

    logic [4:0]       ch_hr_s    [N_ALM];
    logic [5:0]       ch_min_s   [N_ALM];
    logic [N_ALM-1:0] ch_armed_s;
    logic [N_ALM-1:0] match_vec_s;
    logic             tick_zero_s;
    logic             match_any_s;
    logic [SW-1:0]    match_idx_s;

    state_t           state_r;
    logic             ring_r;
    logic [SW-1:0]    ring_ch_r;
    logic [RCW-1:0]   ring_cnt_r;
    logic [SCW-1:0]   snz_cnt_r;
    hm_t              tgt_r;

    assign tick_zero_s = sec_tick && (cur_sec == 6'd0);

    genvar gi;
    generate
        for (gi = 0; gi < N_ALM; gi++) begin : g_ch
            alarm_time_reg u_ch (
                .clk      (clk),
                .rst      (rst),
                .set_mode (set_mode),
                .hr_up    (hr_up   && (sel == SW'(gi))),
                .min_up   (min_up  && (sel == SW'(gi))),
                .arm_tog  (arm_tog && (sel == SW'(gi))),
                .hr       (ch_hr_s[gi]),
                .min      (ch_min_s[gi]),
                .armed    (ch_armed_s[gi])
            );
            assign match_vec_s[gi] = !set_mode && tick_zero_s && ch_armed_s[gi]
                                     && (cur_hr == ch_hr_s[gi]) && (cur_min == ch_min_s[gi]);
        end
    endgenerate

    assign armed_mask = ch_armed_s;

    // Read-back of the selected channel; out-of-range selections read as zero
    always_comb begin
        if (int'(sel) < N_ALM) begin
            sel_hr    = ch_hr_s[sel];
            sel_min   = ch_min_s[sel];
            sel_armed = ch_armed_s[sel];
        end else begin
            sel_hr    = 5'd0;
            sel_min   = 6'd0;
            sel_armed = 1'b0;
        end
    end

    // Lowest matching index wins: scan downward so the last hit kept is the lowest
    always_comb begin
        match_any_s = |match_vec_s;
        match_idx_s = {SW{1'b0}};
        for (int i = N_ALM - 1; i >= 0; i--) begin
            match_idx_s = match_vec_s[i] ? SW'(i) : match_idx_s;
        end
    end

    logic disarm_s;
    logic stop_s;
    logic timeout_s;
    logic snz_req_s;
    logic snz_ok_s;
    logic tgt_hit_s;
    hm_t  snz_tgt_s;

    assign disarm_s  = arm_tog && (sel == ring_ch_r) && armed_mask[ring_ch_r];
    assign stop_s    = dismiss || disarm_s;
    assign timeout_s = sec_tick && (int'(ring_cnt_r) == RING_SEC - 1);
    assign snz_req_s = snooze || timeout_s;
    assign snz_ok_s  = int'(snz_cnt_r) < MAX_SNOOZE;
    assign snz_tgt_s = add_min(cur_hr, cur_min, SNZ_N);
    assign tgt_hit_s = tick_zero_s && (cur_hr == tgt_r.hr) && (cur_min == tgt_r.min);

    // Event FSM with registered ring outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ring_r     <= 1'b0;
            ring_ch_r  <= {SW{1'b0}};
            ring_cnt_r <= {RCW{1'b0}};
            snz_cnt_r  <= {SCW{1'b0}};
            tgt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (match_any_s) begin
                        state_r    <= RING;
                        ring_r     <= 1'b1;
                        ring_ch_r  <= match_idx_s;
                        ring_cnt_r <= {RCW{1'b0}};
                        snz_cnt_r  <= {SCW{1'b0}};
                    end
                end
                RING: begin
                    if (stop_s) begin
                        state_r   <= IDLE;
                        ring_r    <= 1'b0;
                        snz_cnt_r <= {SCW{1'b0}};
                    end else if (snz_req_s && snz_ok_s) begin
                        state_r   <= SNOOZE;
                        ring_r    <= 1'b0;
                        tgt_r     <= snz_tgt_s;
                        snz_cnt_r <= snz_cnt_r + SCW'(1);
                    end else if (snz_req_s) begin
                        state_r   <= IDLE;
                        ring_r    <= 1'b0;
                        snz_cnt_r <= {SCW{1'b0}};
                    end else if (sec_tick) begin
                        ring_cnt_r <= ring_cnt_r + RCW'(1);
                    end
                end
                SNOOZE: begin
                    if (stop_s) begin
                        state_r   <= IDLE;
                        ring_r    <= 1'b0;
                        snz_cnt_r <= {SCW{1'b0}};
                    end else if (tgt_hit_s) begin
                        state_r    <= RING;
                        ring_r     <= 1'b1;
                        ring_cnt_r <= {RCW{1'b0}};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ring_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ring    = ring_r;
    assign ring_ch = ring_ch_r;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expectations queued with stimulus, drained per scenario.
module tb_alarm_bank;

    localparam int N_ALM = 4;
    localparam int SW    = 2;
    localparam int SNZ   = 5;

    logic             clk = 1'b0;
    logic             rst, sec_tick, set_mode, hr_up, min_up, arm_tog, snooze, dismiss;
    logic [4:0]       cur_hr, sel_hr;
    logic [5:0]       cur_min, cur_sec, sel_min;
    logic [SW-1:0]    sel, ring_ch;
    logic             sel_armed, ring;
    logic [N_ALM-1:0] armed_mask;

    typedef struct {
        string       name;
        logic [31:0] val;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    checks = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    alarm_bank #(.N_ALM(N_ALM), .SNOOZE_MIN(SNZ), .RING_SEC(60), .MAX_SNOOZE(3)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .cur_hr(cur_hr), .cur_min(cur_min),
        .cur_sec(cur_sec), .set_mode(set_mode), .sel(sel), .hr_up(hr_up), .min_up(min_up),
        .arm_tog(arm_tog), .snooze(snooze), .dismiss(dismiss), .sel_hr(sel_hr),
        .sel_min(sel_min), .sel_armed(sel_armed), .armed_mask(armed_mask), .ring(ring),
        .ring_ch(ring_ch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input logic [31:0] v);
        exp_q.push_back('{name: n, val: v});
    endtask

    task automatic observe(input string n, input logic [31:0] v);
        obs_q.push_back('{name: n, val: v});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int ch, input int h, input int m, input bit arm);
        set_mode = 1'b1;
        sel      = SW'(ch);
        hr_up    = 1'b1;
        repeat (h) tick();
        hr_up    = 1'b0;
        min_up   = 1'b1;
        repeat (m) tick();
        min_up   = 1'b0;
        if (arm) begin
            arm_tog = 1'b1;
            tick();
            arm_tog = 1'b0;
        end
        set_mode = 1'b0;
    endtask

    // One clock with the given time and pulses; minutes beyond 59 are folded into the day
    task automatic step(input int h, input int m, input int s, input bit tk, input bit snz, input bit dis);
        int t;
        t        = (h * 60 + m) % 1440;
        cur_hr   = 5'(t / 60);
        cur_min  = 6'(t % 60);
        cur_sec  = 6'(s);
        sec_tick = tk;
        snooze   = snz;
        dismiss  = dis;
        tick();
        sec_tick = 1'b0;
        snooze   = 1'b0;
        dismiss  = 1'b0;
    endtask

    task automatic drain();
        item_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL %s: nothing observed, required %0d", e.name, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %0d required %0d", e.name, o.val, e.val);
                else passed++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; sec_tick = 1'b0; set_mode = 1'b0; hr_up = 1'b0; min_up = 1'b0;
        arm_tog = 1'b0; snooze = 1'b0; dismiss = 1'b0; sel = '0;
        cur_hr = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
        tick(); tick();
        rst = 1'b0;
        sel = 2'd3;
        #1;
        expect_v("rst_ring", 0);       observe("rst_ring", ring);
        expect_v("rst_ring_ch", 0);    observe("rst_ring_ch", ring_ch);
        expect_v("rst_armed_mask", 0); observe("rst_armed_mask", armed_mask);
        expect_v("rst_sel_hr", 0);     observe("rst_sel_hr", sel_hr);
        expect_v("rst_sel_min", 0);    observe("rst_sel_min", sel_min);
        expect_v("rst_sel_armed", 0);  observe("rst_sel_armed", sel_armed);
        drain();
    endtask

    task automatic test_match();
        do_reset();
        set_ch(2, 7, 30, 1'b1);
        expect_v("match_sel_hr", 7);     observe("match_sel_hr", sel_hr);
        expect_v("match_sel_min", 30);   observe("match_sel_min", sel_min);
        expect_v("match_mask", 4'b0100); observe("match_mask", armed_mask);
        step(7, 30, 0, 1'b1, 1'b0, 1'b0);
        expect_v("match_ring", 1);       observe("match_ring", ring);
        expect_v("match_ring_ch", 2);    observe("match_ring_ch", ring_ch);
        step(7, 30, 5, 1'b0, 1'b0, 1'b1);
        expect_v("match_dismissed", 0);  observe("match_dismissed", ring);
        arm_tog = 1'b1; tick(); arm_tog = 1'b0;
        expect_v("disarm_mask", 0);      observe("disarm_mask", armed_mask);
        step(7, 30, 0, 1'b1, 1'b0, 1'b0);
        expect_v("disarmed_no_ring", 0); observe("disarmed_no_ring", ring);
        arm_tog = 1'b1; tick(); arm_tog = 1'b0;
        set_mode = 1'b1;
        step(7, 30, 0, 1'b1, 1'b0, 1'b0);
        set_mode = 1'b0;
        expect_v("setmode_blocks", 0);   observe("setmode_blocks", ring);
        drain();
    endtask

    task automatic test_priority();
        do_reset();
        set_ch(0, 6, 0, 1'b1);
        set_ch(3, 6, 0, 1'b1);
        expect_v("prio_mask", 4'b1001); observe("prio_mask", armed_mask);
        step(6, 0, 0, 1'b1, 1'b0, 1'b0);
        expect_v("prio_ring", 1);       observe("prio_ring", ring);
        expect_v("prio_ring_ch", 0);    observe("prio_ring_ch", ring_ch);
        step(6, 0, 0, 1'b0, 1'b0, 1'b1);
        expect_v("prio_dismiss", 0);    observe("prio_dismiss", ring);
        step(6, 0, 1, 1'b1, 1'b0, 1'b0);
        step(6, 0, 2, 1'b1, 1'b0, 1'b0);
        expect_v("prio_ch3_dropped", 0); observe("prio_ch3_dropped", ring);
        drain();
    endtask

    task automatic test_snooze_wrap();
        int tgt;
        do_reset();
        set_ch(1, 23, 58, 1'b1);
        step(23, 58, 0, 1'b1, 1'b0, 1'b0);
        expect_v("wrap_ring", 1);      observe("wrap_ring", ring);
        expect_v("wrap_ring_ch", 1);   observe("wrap_ring_ch", ring_ch);
        step(23, 58, 20, 1'b1, 1'b1, 1'b0);
        expect_v("wrap_snoozed", 0);   observe("wrap_snoozed", ring);
        tgt = (23 * 60 + 58 + SNZ) % 1440;
        step(0, tgt - 1, 0, 1'b1, 1'b0, 1'b0);
        expect_v("wrap_early", 0);     observe("wrap_early", ring);
        step(0, tgt, 0, 1'b1, 1'b0, 1'b0);
        expect_v("wrap_rering", 1);    observe("wrap_rering", ring);
        expect_v("wrap_rering_ch", 1); observe("wrap_rering_ch", ring_ch);
        step(0, tgt, 1, 1'b0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_max_snooze();
        int t;
        do_reset();
        set_ch(0, 10, 0, 1'b1);
        t = 600;
        step(0, t, 0, 1'b1, 1'b0, 1'b0);
        expect_v("max_ring0", 1); observe("max_ring0", ring);
        for (int k = 0; k < 3; k++) begin
            step(0, t, 10, 1'b0, 1'b1, 1'b0);
            expect_v($sformatf("max_snz%0d", k), 0);   observe($sformatf("max_snz%0d", k), ring);
            t = t + SNZ;
            step(0, t, 0, 1'b1, 1'b0, 1'b0);
            expect_v($sformatf("max_rering%0d", k), 1); observe($sformatf("max_rering%0d", k), ring);
        end
        step(0, t, 10, 1'b0, 1'b1, 1'b0);
        expect_v("max_final_snooze", 0); observe("max_final_snooze", ring);
        step(0, t + SNZ, 0, 1'b1, 1'b0, 1'b0);
        expect_v("max_no_rering", 0);    observe("max_no_rering", ring);
        drain();
    endtask

    task automatic test_timeout();
        do_reset();
        set_ch(0, 12, 0, 1'b1);
        step(12, 0, 0, 1'b1, 1'b0, 1'b0);
        expect_v("to_ring", 1); observe("to_ring", ring);
        for (int s = 1; s < 60; s++) step(12, 0, s, 1'b1, 1'b0, 1'b0);
        expect_v("to_still_ring", 1); observe("to_still_ring", ring);
        step(12, 1, 0, 1'b1, 1'b0, 1'b0);
        expect_v("to_auto_snooze", 0); observe("to_auto_snooze", ring);
        step(12, 1 + SNZ - 1, 0, 1'b1, 1'b0, 1'b0);
        expect_v("to_early", 0); observe("to_early", ring);
        step(12, 1 + SNZ, 0, 1'b1, 1'b0, 1'b0);
        expect_v("to_rering", 1); observe("to_rering", ring);
        drain();
    endtask

    task automatic test_edit();
        do_reset();
        set_ch(1, 22, 59, 1'b0);
        expect_v("edit_hr", 22);  observe("edit_hr", sel_hr);
        expect_v("edit_min", 59); observe("edit_min", sel_min);
        set_mode = 1'b1; hr_up = 1'b1; min_up = 1'b1;
        tick();
        hr_up = 1'b0; min_up = 1'b0; set_mode = 1'b0;
        expect_v("double_hr", 0);  observe("double_hr", sel_hr);
        expect_v("double_min", 0); observe("double_min", sel_min);
        set_ch(1, 23, 59, 1'b0);
        set_mode = 1'b1; min_up = 1'b1;
        tick();
        min_up = 1'b0; set_mode = 1'b0;
        expect_v("wrap_day_hr", 0);  observe("wrap_day_hr", sel_hr);
        expect_v("wrap_day_min", 0); observe("wrap_day_min", sel_min);
        hr_up = 1'b1; tick(); hr_up = 1'b0;
        expect_v("edit_locked", 0);  observe("edit_locked", sel_hr);
        drain();
    endtask

    task automatic test_rst_mid_ring();
        do_reset();
        set_ch(2, 5, 5, 1'b1);
        set_ch(0, 0, 0, 1'b1);
        step(5, 5, 0, 1'b1, 1'b0, 1'b0);
        expect_v("mid_ring", 1);    observe("mid_ring", ring);
        expect_v("mid_ring_ch", 2); observe("mid_ring_ch", ring_ch);
        sel = 2'd2;
        rst = 1'b1;
        tick();
        expect_v("mid_rst_ring", 0);    observe("mid_rst_ring", ring);
        expect_v("mid_rst_ring_ch", 0); observe("mid_rst_ring_ch", ring_ch);
        expect_v("mid_rst_mask", 0);    observe("mid_rst_mask", armed_mask);
        expect_v("mid_rst_hr", 0);      observe("mid_rst_hr", sel_hr);
        expect_v("mid_rst_min", 0);     observe("mid_rst_min", sel_min);
        rst = 1'b0;
        step(5, 5, 0, 1'b1, 1'b0, 1'b0);
        expect_v("mid_rst_quiet", 0);   observe("mid_rst_quiet", ring);
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ch(0, 8, 0, 1'b1);
        step(8, 0, 0, 1'b1, 1'b0, 1'b0);
        expect_v("ds_ring", 1);    observe("ds_ring", ring);
        step(8, 0, 3, 1'b0, 1'b1, 1'b1);
        expect_v("ds_stop", 0);    observe("ds_stop", ring);
        step(8, SNZ, 0, 1'b1, 1'b0, 1'b0);
        expect_v("ds_no_snz", 0);  observe("ds_no_snz", ring);
        set_ch(3, 9, 0, 1'b1);
        step(9, 0, 0, 1'b1, 1'b0, 1'b0);
        expect_v("dis_ring_ch", 3); observe("dis_ring_ch", ring_ch);
        arm_tog = 1'b1; tick(); arm_tog = 1'b0;
        expect_v("dis_ring", 0);    observe("dis_ring", ring);
        expect_v("dis_mask", 4'b0001); observe("dis_mask", armed_mask);
        step(9, SNZ, 0, 1'b1, 1'b0, 1'b0);
        expect_v("dis_quiet", 0);   observe("dis_quiet", ring);
        drain();
    endtask

    initial begin
        test_reset();
        test_match();
        test_priority();
        test_snooze_wrap();
        test_max_snooze();
        test_timeout();
        test_edit();
        test_rst_mid_ring();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
